column_frame_loader: RTL

- Sits at the north terminal of each fabric column, directly above the column's single-terminal tile.
- Feeds the tiles below with configuration: accepts a word stream over a valid/ready handshake and assembles one frame of FrameBitsPerRow bits per row.
- Once a frame is complete, pulses that frame's strobe so every tile in the column latches it.
- Reports errors on malformed headers and counts completed frames.

---
 rtl/column_frame_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/column_frame_loader.sv
// Column configuration frame loader: assembles one frame of NumRows words from a
// valid/ready stream, then pulses that frame's one-hot strobe to the tiles below.
module column_frame_loader #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NumRows         = 16
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 in_valid,
  input  logic [FrameBitsPerRow-1:0]           in_data,
  output logic                                 in_ready,
  output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 busy,
  output logic                                 error,
  output logic [15:0]                          frames_done
);

  localparam int unsigned    RowW     = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);
  localparam logic [15:0]    SyncWord = 16'hFAB0;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDiscard,
    StStrobe,
    StHold
  } state_e;

  state_e                               state_q, state_d;
  logic [4:0]                           index_q, index_d;
  logic [RowW-1:0]                      row_q, row_d;
  logic [FrameBitsPerRow*NumRows-1:0]   frame_q, frame_d;
  logic [MaxFramesPerCol-1:0]           strobe_q, strobe_d;
  logic                                 error_q, error_d;
  logic [15:0]                          done_q, done_d;

  logic       xfer;
  logic       hdr_sync_ok;
  logic       hdr_idx_ok;
  logic [4:0] hdr_idx;

  assign in_ready    = (state_q == StIdle) || (state_q == StLoad) || (state_q == StDiscard);
  assign xfer        = in_valid && in_ready;
  assign hdr_sync_ok = (in_data[31:16] == SyncWord);
  assign hdr_idx     = in_data[4:0];
  assign hdr_idx_ok  = (32'(hdr_idx) < MaxFramesPerCol);

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    row_d    = row_q;
    frame_d  = frame_q;
    strobe_d = '0;
    error_d  = error_q;
    done_d   = done_q;

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (!hdr_sync_ok) begin
            error_d = 1'b1;
          end else if (hdr_idx_ok) begin
            index_d = hdr_idx;
            row_d   = '0;
            state_d = StLoad;
          end else begin
            error_d = 1'b1;
            row_d   = '0;
            state_d = StDiscard;
          end
        end
      end
      StLoad: begin
        if (xfer) begin
          frame_d[row_q*FrameBitsPerRow +: FrameBitsPerRow] = in_data;
          if (row_q == LastRow) begin
            // Strobe and count are registered together so both show in StStrobe.
            row_d             = '0;
            strobe_d[index_q] = 1'b1;
            done_d            = done_q + 16'd1;
            state_d           = StStrobe;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      StDiscard: begin
        if (xfer) begin
          if (row_q == LastRow) begin
            row_d   = '0;
            state_d = StIdle;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      StStrobe: state_d = StHold;
      StHold:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      index_q  <= '0;
      row_q    <= '0;
      frame_q  <= '0;
      strobe_q <= '0;
      error_q  <= 1'b0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      row_q    <= row_d;
      frame_q  <= frame_d;
      strobe_q <= strobe_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

  // Named alias kept so the counter register can be addressed directly.
  logic [15:0] frames_done_q;
  assign frames_done_q = done_q;

  assign FrameData   = frame_q;
  assign FrameStrobe = strobe_q;
  assign busy        = (state_q != StIdle);
  assign error       = error_q;
  assign frames_done = frames_done_q;

endmodule
